// File: rtl/booth_mult_sequencer.sv
// Operand FIFO and Start/Ready sequencer for the sequential Booth multiplier.
// Issues one operand pair at a time and returns products in issue order.
module booth_mult_sequencer #(
  parameter int unsigned L_WORD     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [L_WORD-1:0]             in_a,
  input  logic [L_WORD-1:0]             in_x,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*L_WORD-1:0]           out_product,
  output logic [TAG_W-1:0]              out_tag,
  output logic [L_WORD-1:0]             mult_a,
  output logic [L_WORD-1:0]             mult_x,
  output logic                          mult_start,
  input  logic                          mult_ready,
  input  logic [2*L_WORD-1:0]           mult_product,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [L_WORD-1:0] mem_a   [FIFO_DEPTH];
  logic [L_WORD-1:0] mem_x   [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic [L_WORD-1:0]   op_a_q, op_x_q;
  logic [TAG_W-1:0]    op_tag_q;
  logic                out_valid_q, out_valid_d;
  logic [2*L_WORD-1:0] out_product_q;
  logic [TAG_W-1:0]    out_tag_q;

  logic push, pop, capture;

  assign in_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;

  // FIFO storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]   <= in_a;
      mem_x[wr_ptr_q]   <= in_x;
      mem_tag[wr_ptr_q] <= in_tag;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && mult_ready) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (mult_ready && (!out_valid_q || out_ready)) begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (capture) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      op_a_q        <= '0;
      op_x_q        <= '0;
      op_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_tag_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        op_a_q   <= mem_a[rd_ptr_q];
        op_x_q   <= mem_x[rd_ptr_q];
        op_tag_q <= mem_tag[rd_ptr_q];
      end
      if (capture) begin
        out_product_q <= mult_product;
        out_tag_q     <= op_tag_q;
      end
    end
  end

  assign mult_a      = op_a_q;
  assign mult_x      = op_x_q;
  assign mult_start  = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_tag     = out_tag_q;
  assign fifo_count  = count_q;

endmodule
